elevator_scheduler: RTL and testbench

Sequencing controller for the three-floor elevator. Latches active-low hall-call buttons and chooses travel direction with a SCAN policy (keep going while calls remain ahead, otherwise reverse). Times floor-to-floor travel and door dwell, then clears each call when its floor is served. It drives the floor indicator and motion/door status used by the rest of the elevator design.

---
 rtl/elevator_scheduler_pkg.sv | 45 ++++
 rtl/elevator_scheduler_call_reg.sv | 27 ++
 rtl/elevator_scheduler.sv | 138 +++++++++++++
 tb/tb_elevator_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_scheduler_pkg.sv
// Shared definitions for the elevator scheduler: FSM states, floor codes,
// timer width and small floor-indexing helpers.
package elevator_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  localparam logic [1:0] FLOOR1 = 2'b01;
  localparam logic [1:0] FLOOR2 = 2'b10;
  localparam logic [1:0] FLOOR3 = 2'b11;

  localparam int TIMER_W = 4;

  // Select the bit of a per-floor vector that belongs to floor code f.
  function automatic logic floor_bit(input logic [3:1] v, input logic [1:0] f);
    case (f)
      FLOOR1:  floor_bit = v[1];
      FLOOR2:  floor_bit = v[2];
      FLOOR3:  floor_bit = v[3];
      default: floor_bit = 1'b0;
    endcase
  endfunction

  function automatic logic calls_ahead(input logic [3:1] c, input logic [1:0] f,
                                       input logic up);
    calls_ahead = 1'b0;
    if (up) begin
      case (f)
        FLOOR1:  calls_ahead = c[2] | c[3];
        FLOOR2:  calls_ahead = c[3];
        default: calls_ahead = 1'b0;
      endcase
    end else begin
      case (f)
        FLOOR3:  calls_ahead = c[1] | c[2];
        FLOOR2:  calls_ahead = c[1];
        default: calls_ahead = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/elevator_scheduler_call_reg.sv
// One pending-call flop: set by a hall press, cleared when the floor is served.
// Clear has priority so a press on the arrival edge does not re-arm the call.
module elevator_call_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic call_q;
  logic call_d;

  always_comb begin
    call_d = call_q;
    if (clr)      call_d = 1'b0;
    else if (set) call_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) call_q <= 1'b0;
    else        call_q <= call_d;
  end

  assign q = call_q;

endmodule

// File: rtl/elevator_scheduler.sv
// Three-floor elevator sequencer: latches hall calls, picks direction with a
// SCAN policy and times travel and door dwell with one shared down-counter.
module elevator_scheduler
  import elevator_scheduler_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:1] B,
  output logic [3:1] C,
  output logic [1:0] O,
  output logic       UP,
  output logic       MOVING,
  output logic       DOOR,
  output logic       ARRIVE
);

  // Timer holds remaining cycles minus one, so it expires on the last cycle.
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  state_e               state_q,  state_d;
  logic [1:0]           floor_q,  floor_d;
  logic                 up_q,     up_d;
  logic [TIMER_W-1:0]   timer_q,  timer_d;
  logic                 moving_q, moving_d;
  logic                 door_q,   door_d;
  logic                 arrive_q, arrive_d;

  logic [3:1] call_q;
  logic [3:1] call_set;
  logic [3:1] call_clr;
  logic       cur_press;
  logic       no_latch;
  logic       eff_up;
  logic       enter_door;
  logic [1:0] door_floor;

  assign cur_press = floor_bit(~B, floor_q);
  assign no_latch  = (state_q != ST_MOVE);
  // Direction is pinned at the end floors before the SCAN decision.
  assign eff_up    = (floor_q == FLOOR3) ? 1'b0 :
                     (floor_q == FLOOR1) ? 1'b1 : up_q;

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    up_d       = up_q;
    timer_d    = timer_q;
    enter_door = 1'b0;
    door_floor = floor_q;
    case (state_q)
      ST_IDLE: begin
        if (cur_press) begin
          state_d    = ST_DOOR;
          timer_d    = DOOR_LOAD;
          enter_door = 1'b1;
        end else if (calls_ahead(call_q, floor_q, eff_up)) begin
          state_d = ST_MOVE;
          up_d    = eff_up;
          timer_d = TRAVEL_LOAD;
        end else if (calls_ahead(call_q, floor_q, ~eff_up)) begin
          state_d = ST_MOVE;
          up_d    = ~eff_up;
          timer_d = TRAVEL_LOAD;
        end
      end
      ST_MOVE: begin
        if (timer_q == '0) begin
          floor_d = up_q ? (floor_q + 2'd1) : (floor_q - 2'd1);
          if (floor_bit(call_q, floor_d)) begin
            state_d    = ST_DOOR;
            timer_d    = DOOR_LOAD;
            enter_door = 1'b1;
            door_floor = floor_d;
          end else begin
            timer_d = TRAVEL_LOAD;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_DOOR: begin
        if (cur_press)            timer_d = DOOR_LOAD;
        else if (timer_q == '0)   state_d = ST_IDLE;
        else                      timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    moving_d = (state_d == ST_MOVE);
    door_d   = (state_d == ST_DOOR);
    arrive_d = enter_door;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      floor_q  <= FLOOR1;
      up_q     <= 1'b1;
      timer_q  <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      arrive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      up_q     <= up_d;
      timer_q  <= timer_d;
      moving_q <= moving_d;
      door_q   <= door_d;
      arrive_q <= arrive_d;
    end
  end

  // A press at the current floor while stopped opens the door instead of latching.
  for (genvar i = 1; i <= 3; i++) begin : g_call
    assign call_set[i] = ~B[i] & ~(no_latch & (floor_q == 2'(i)));
    assign call_clr[i] = enter_door & (door_floor == 2'(i));

    elevator_call_reg u_call_reg (
      .clk   (CLK),
      .rst_n (RST_N),
      .set   (call_set[i]),
      .clr   (call_clr[i]),
      .q     (call_q[i])
    );
  end

  assign C      = call_q;
  assign O      = floor_q;
  assign UP     = up_q;
  assign MOVING = moving_q;
  assign DOOR   = door_q;
  assign ARRIVE = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios with literal expectations
// plus a long randomized run checked every cycle against a behavioural model.
module tb_elevator_scheduler;

  localparam int TRAVEL_CYCLES = 4;
  localparam int DOOR_CYCLES   = 3;

  logic       CLK;
  logic       RST_N;
  logic [3:1] B;
  logic [3:1] C;
  logic [1:0] O;
  logic       UP;
  logic       MOVING;
  logic       DOOR;
  logic       ARRIVE;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  elevator_scheduler #(
    .TRAVEL_CYCLES (TRAVEL_CYCLES),
    .DOOR_CYCLES   (DOOR_CYCLES)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .B      (B),
    .C      (C),
    .O      (O),
    .UP     (UP),
    .MOVING (MOVING),
    .DOOR   (DOOR),
    .ARRIVE (ARRIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: floor as an integer, mode 0=idle 1=moving 2=door,
  // m_left = cycles still to spend in the current travel or door interval.
  int       m_floor = 1;
  bit       m_up    = 1'b1;
  bit [3:1] m_calls = '0;
  int       m_mode  = 0;
  int       m_left  = 0;
  bit       m_arrive = 1'b0;
  bit [3:1] press;
  int       f0, mode0, served, d;

  function automatic bit any_call(bit [3:1] c, int from, int dir);
    for (int f = 1; f <= 3; f++)
      if (c[f] && (f - from) * dir > 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_floor = 1; m_up = 1'b1; m_calls = '0; m_mode = 0; m_left = 0; m_arrive = 1'b0;
    end else begin
      press = ~B;
      f0 = m_floor; mode0 = m_mode; served = 0;
      case (m_mode)
        0: begin
          if (press[f0]) begin
            m_mode = 2; m_left = DOOR_CYCLES; served = f0;
          end else begin
            d = (f0 == 3) ? -1 : (f0 == 1) ? 1 : (m_up ? 1 : -1);
            if (!any_call(m_calls, f0, d)) d = -d;
            if (any_call(m_calls, f0, d)) begin
              m_mode = 1; m_left = TRAVEL_CYCLES; m_up = (d > 0);
            end
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_floor += m_up ? 1 : -1;
            if (m_calls[m_floor]) begin
              m_mode = 2; m_left = DOOR_CYCLES; served = m_floor;
            end else begin
              m_left = TRAVEL_CYCLES;
            end
          end
        end
        default: begin
          if (press[f0]) m_left = DOOR_CYCLES;
          else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
          end
        end
      endcase
      for (int f = 1; f <= 3; f++) begin
        if (served == f) m_calls[f] = 1'b0;
        else if (press[f] && !(mode0 != 1 && f == f0)) m_calls[f] = 1'b1;
      end
      m_arrive = (served != 0);
    end
  end

  logic [9:0] act_v, exp_v;
  always @(negedge CLK) begin
    if (chk_en) begin
      act_v = {C, O, UP, MOVING, DOOR, ARRIVE};
      exp_v = {m_calls, 2'(m_floor), m_up, (m_mode == 1), (m_mode == 2), m_arrive};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t actual C,O,UP,MV,DR,AR=%b required=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic wait_arrive(input string name, input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ARRIVE && n < limit);
    chk(name, 4'(ARRIVE), 4'b1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((DOOR || MOVING) && n < limit) begin
      tick();
      n++;
    end
    chk(name, {2'b00, MOVING, DOOR}, 4'b0000);
  endtask

  logic [3:1] rb;

  initial begin
    RST_N = 1'b0;
    B     = 3'b111;
    repeat (2) tick();
    chk("rst_O", 4'(O), 4'b0001);
    chk("rst_C", 4'(C), 4'b0000);
    chk("rst_flags", {UP, MOVING, DOOR, ARRIVE}, 4'b1000);
    chk_en = 1'b1;
    RST_N  = 1'b1;
    tick();

    // Floor 1 -> floor 3 on a one-cycle press.
    B = 3'b011; tick();
    chk("a_latch_C", 4'(C), 4'b0100);
    chk("a_not_moving_yet", 4'(MOVING), 4'b0);
    B = 3'b111; tick();
    chk("a_move_entry", {2'b00, MOVING, UP}, 4'b0011);
    repeat (3) tick();
    chk("a_still_f1", 4'(O), 4'b0001);
    tick();
    chk("a_f2_pass", {O, MOVING, ARRIVE}, 4'b1010);
    repeat (4) tick();
    chk("a_arrive_f3", {O, DOOR, ARRIVE}, 4'b1111);
    chk("a_C_cleared", 4'(C), 4'b0000);
    chk("a_mv_low", 4'(MOVING), 4'b0);
    tick();
    chk("a_arrive_pulse", {2'b00, DOOR, ARRIVE}, 4'b0010);
    repeat (2) tick();
    chk("a_idle", {2'b00, MOVING, DOOR}, 4'b0000);

    // Floor 3 -> floor 1: direction toggles, floor 2 passed.
    B = 3'b110; tick();
    chk("b_latch_C", 4'(C), 4'b0001);
    B = 3'b111; tick();
    chk("b_up_toggle", {2'b00, MOVING, UP}, 4'b0010);
    repeat (4) tick();
    chk("b_pass_f2", {O, MOVING, ARRIVE}, 4'b1010);
    repeat (4) tick();
    chk("b_arrive_f1", {O, DOOR, ARRIVE}, 4'b0111);
    chk("b_C_cleared", 4'(C), 4'b0000);
    wait_idle("b_idle", 10);

    // Floor 1 going to 3, floor 2 pressed during the first hop.
    B = 3'b011; tick();
    B = 3'b111; tick();
    tick();
    B = 3'b101; tick();
    B = 3'b111;
    chk("c_both_pending", 4'(C), 4'b0110);
    repeat (2) tick();
    chk("c_stop_f2", {O, ARRIVE, UP}, 4'b1011);
    chk("c_C_f3_left", 4'(C), 4'b0100);
    wait_arrive("c_arrive_f3", 20);
    chk("c_at_f3", {O, DOOR, UP}, 4'b1111);
    chk("c_C_empty", 4'(C), 4'b0000);
    wait_idle("c_idle", 10);

    // Door at floor 2 held open by a held button.
    B = 3'b101; tick();
    B = 3'b111;
    wait_arrive("d_arrive_f2", 20);
    chk("d_at_f2", 4'(O), 4'b0010);
    B = 3'b101;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("d_door_held", {1'b0, C[2], MOVING, DOOR}, 4'b0001);
    end
    B = 3'b111;
    repeat (2) tick();
    chk("d_door_tail", 4'(DOOR), 4'b1);
    tick();
    chk("d_door_closed", 4'(DOOR), 4'b0);

    // Arrival at floor 2 while floor 2 is held: clear wins, door held.
    B = 3'b110; tick();
    B = 3'b111;
    wait_arrive("e_arrive_f1", 20);
    chk("e_at_f1", 4'(O), 4'b0001);
    wait_idle("e_idle_f1", 10);
    B = 3'b101;
    wait_arrive("e_arrive_f2", 20);
    chk("e_clear_wins", {C, DOOR}, 4'b0001);
    chk("e_at_f2", 4'(O), 4'b0010);
    repeat (5) tick();
    chk("e_held_door", {C, DOOR}, 4'b0001);
    B = 3'b111;
    wait_idle("e_idle_f2", 10);

    // Asynchronous reset in the middle of travel.
    B = 3'b011; tick();
    B = 3'b111;
    repeat (3) tick();
    RST_N = 1'b0;
    #1;
    chk("f_async_O", 4'(O), 4'b0001);
    chk("f_async_C", 4'(C), 4'b0000);
    chk("f_async_mv", {2'b00, MOVING, DOOR}, 4'b0000);
    tick();
    chk("f_rst_held", {O, MOVING, UP}, 4'b0101);
    RST_N = 1'b1;

    // Randomized traffic, occasional held buttons and resets.
    rb = 3'b111;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        rb = 3'b111;
        for (int f = 1; f <= 3; f++)
          if ($urandom_range(0, 9) == 0) rb[f] = 1'b0;
      end
      B = rb;
      if ($urandom_range(0, 799) == 0) begin
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
      end
      tick();
    end
    B = 3'b111;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
